gc_garble_sequencer: RTL and testbench

// - Sequences gate-by-gate garbling of a netlist over multiple sequential clock cycles (CCs).
// - Free XOR/XNOR/NOT gates advance gid with no engine slot.
// - Non-XOR gates issue to the pipelined GC engine; the engine returns t0/t1 LAT cycles later.
// - Garbled-table pairs stream out through a credit-guarded FIFO with valid/ready backpressure.
// - Sits between the netlist ROM / GC engine and the garbled-table transport.

---
 rtl/gc_garble_sequencer.sv | 230 +++++++++++++++++++++++
 tb/tb_gc_garble_sequencer.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gc_garble_sequencer.sv
// gc_garble_sequencer
//   Walks a netlist gate by gate for num_cc clock cycles (CCs). Free gates
//   (XOR/XNOR/NOT) only advance gid; every other gate is issued to a pipelined
//   GC engine whose t0/t1 rows return LAT cycles later. A LAT-deep delay line
//   carries {idx,cc} alongside the engine so each returning pair is tagged and
//   pushed into a show-ahead output FIFO. Issue is credit-guarded:
//   fifo_cnt + inflight (minus a same-cycle pop) must stay below FD, so a push
//   can never meet a full FIFO.
//   Optional feature macro: GC_SEQ_PERF_CNT_EN adds stall_cnt / xor_cnt.
//   state_dbg exposes the FSM state (0 IDLE, 1 RUN, 2 DRAIN, 3 DONE).
module gc_garble_sequencer #(
  parameter int S   = 20,
  parameter int K   = 128,
  parameter int LAT = 10,
  parameter int FD  = 16,
  parameter int CCW = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [S-1:0]   num_gates,
  input  logic [CCW-1:0] num_cc,
  output logic           busy,
  output logic           done,
  output logic [S-1:0]   gid,
  input  logic           g_is_xor,
  output logic           eng_issue,
  input  logic [K-1:0]   eng_t0,
  input  logic [K-1:0]   eng_t1,
  output logic           gt_valid,
  input  logic           gt_ready,
  output logic [2*K-1:0] gt_data,
  output logic [S-1:0]   gt_idx,
  output logic [CCW-1:0] gt_cc,
`ifdef GC_SEQ_PERF_CNT_EN
  output logic [31:0]    stall_cnt,
  output logic [S-1:0]   xor_cnt,
`endif
  output logic [1:0]     state_dbg
);

  localparam int FAW = $clog2(FD);
  localparam int EW  = 2*K + S + CCW;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t         state;
  logic [S-1:0]   ng_r;
  logic [S-1:0]   idx;
  logic [CCW-1:0] cc;
  logic [CCW-1:0] last_cc_r;

  logic           dl_valid [LAT];
  logic [S-1:0]   dl_idx   [LAT];
  logic [CCW-1:0] dl_cc    [LAT];

  logic [EW-1:0]  mem [FD];
  logic [FAW-1:0] wr_ptr;
  logic [FAW-1:0] rd_ptr;
  logic [FAW:0]   fifo_cnt;
  logic [EW-1:0]  head;

  logic [31:0]    inflight;
  logic           push;
  logic           pop;
  logic           credit_ok;
  logic           gate_sel;
  logic           advance;
  logic           issue;
  logic           last_gate;
  logic           last_cc;

  // Output handshake: the head entry transfers on a cycle where gt_valid and
  // gt_ready are both high at the rising edge; gt_valid never drops and gt_*
  // never change while an entry is waiting, and gt_ready may toggle freely.

  assign state_dbg = state;

  // Count engine operations in flight (valid slots of the delay line).
  always_comb begin
    inflight = '0;
    for (int i = 0; i < LAT; i++) begin
      inflight = inflight + 32'(dl_valid[i]);
    end
  end

  assign push      = dl_valid[LAT-1];
  assign gt_valid  = (fifo_cnt != '0);
  assign pop       = gt_valid && gt_ready;
  assign credit_ok = (32'(fifo_cnt) + inflight - 32'(pop)) < 32'(FD);
  assign gate_sel  = (state == RUN) && (ng_r != '0);
  assign issue     = gate_sel && !g_is_xor && credit_ok;
  assign advance   = gate_sel && (g_is_xor || credit_ok);
  assign eng_issue = issue;
  assign last_gate = (gid == (ng_r - S'(1)));
  assign last_cc   = (cc == last_cc_r);

  // Run control FSM: gate walk, CC wrap, drain and done pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      gid       <= '0;
      idx       <= '0;
      cc        <= '0;
      ng_r      <= '0;
      last_cc_r <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            ng_r      <= num_gates;
            last_cc_r <= (num_cc == '0) ? '0 : num_cc - CCW'(1);
            gid       <= '0;
            idx       <= '0;
            cc        <= '0;
            busy      <= 1'b1;
            state     <= RUN;
          end
        end
        RUN: begin
          if (ng_r == '0) begin
            state <= DRAIN;
          end else if (advance) begin
            if (last_gate) begin
              gid <= '0;
              idx <= '0;
              if (last_cc) begin
                cc    <= '0;
                state <= DRAIN;
              end else begin
                cc <= cc + CCW'(1);
              end
            end else begin
              gid <= gid + S'(1);
              if (issue) idx <= idx + S'(1);
            end
          end
        end
        DRAIN: begin
          if (inflight == '0 && fifo_cnt == '0) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end
        end
        default: begin
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

  // Delay line tracking the engine pipeline: one {valid,idx,cc} per stage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < LAT; i++) begin
        dl_valid[i] <= 1'b0;
        dl_idx[i]   <= '0;
        dl_cc[i]    <= '0;
      end
    end else begin
      for (int i = LAT - 1; i > 0; i--) begin
        dl_valid[i] <= dl_valid[i-1];
        dl_idx[i]   <= dl_idx[i-1];
        dl_cc[i]    <= dl_cc[i-1];
      end
      dl_valid[0] <= issue;
      dl_idx[0]   <= idx;
      dl_cc[0]    <= cc;
    end
  end

  // FIFO storage; contents need no reset because fifo_cnt gates visibility.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {eng_t1, eng_t0, dl_idx[LAT-1], dl_cc[LAT-1]};
  end

  // FIFO pointers and occupancy; pointers wrap naturally since FD is 2^n.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + FAW'(1);
      if (pop)  rd_ptr <= rd_ptr + FAW'(1);
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + (FAW+1)'(1);
        2'b01:   fifo_cnt <= fifo_cnt - (FAW+1)'(1);
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  assign head    = mem[rd_ptr];
  assign gt_data = gt_valid ? head[EW-1 -: 2*K]   : '0;
  assign gt_idx  = gt_valid ? head[CCW +: S]      : '0;
  assign gt_cc   = gt_valid ? head[CCW-1:0]       : '0;

  // The credit rule must make a push into a full FIFO impossible.
  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(push && !pop && fifo_cnt == (FAW+1)'(FD)));

`ifdef GC_SEQ_PERF_CNT_EN
  // Saturating performance counters, cleared when a run starts.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
      xor_cnt   <= '0;
    end else if (state == IDLE && start) begin
      stall_cnt <= '0;
      xor_cnt   <= '0;
    end else begin
      if (gate_sel && !g_is_xor && !credit_ok && stall_cnt != '1)
        stall_cnt <= stall_cnt + 32'd1;
      if (gate_sel && g_is_xor && xor_cnt != '1)
        xor_cnt <= xor_cnt + S'(1);
    end
  end
`endif

endmodule

// File: tb/tb_gc_garble_sequencer.sv
// tb_gc_garble_sequencer
//   Netlist ROM and GC engine are modelled around the DUT. At each launch the
//   expected output stream is derived from the netlist flags: every non-free
//   gate of every CC yields one entry {t1,t0,idx,cc}, with idx counting
//   non-free gates within the CC. The k-th engine issue returns random rows
//   chosen up front, so the expected queue is filled before the run starts.
module tb_gc_garble_sequencer;

  localparam int S    = 20;
  localparam int K    = 128;
  localparam int LAT  = 10;
  localparam int FD   = 16;
  localparam int CCW  = 8;
  localparam int EW   = 2*K + S + CCW;
  localparam int MAXG = 128;
  localparam int MAXI = 256;

  // ---------------- clock / reset / DUT ----------------
  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           start = 1'b0;
  logic [S-1:0]   num_gates = '0;
  logic [CCW-1:0] num_cc = '0;
  logic           busy, done, eng_issue, gt_valid, g_is_xor;
  logic           gt_ready = 1'b0;
  logic [S-1:0]   gid, gt_idx;
  logic [K-1:0]   eng_t0 = '0;
  logic [K-1:0]   eng_t1 = '0;
  logic [2*K-1:0] gt_data;
  logic [CCW-1:0] gt_cc;
  logic [1:0]     state_dbg;
`ifdef GC_SEQ_PERF_CNT_EN
  logic [31:0]    stall_cnt;
  logic [S-1:0]   xor_cnt;
`endif

  always #5 clk = ~clk;

  gc_garble_sequencer #(.S(S), .K(K), .LAT(LAT), .FD(FD), .CCW(CCW)) dut (
    .clk(clk), .rst(rst), .start(start), .num_gates(num_gates), .num_cc(num_cc),
    .busy(busy), .done(done), .gid(gid), .g_is_xor(g_is_xor), .eng_issue(eng_issue),
    .eng_t0(eng_t0), .eng_t1(eng_t1), .gt_valid(gt_valid), .gt_ready(gt_ready),
    .gt_data(gt_data), .gt_idx(gt_idx), .gt_cc(gt_cc),
`ifdef GC_SEQ_PERF_CNT_EN
    .stall_cnt(stall_cnt), .xor_cnt(xor_cnt),
`endif
    .state_dbg(state_dbg)
  );

  // Netlist ROM: combinational free-gate flag for the current gid.
  logic xor_flag [MAXG];
  assign g_is_xor = (gid < S'(MAXG)) ? xor_flag[gid[6:0]] : 1'b0;

  // ---------------- scoreboard / model state ----------------
  logic [EW-1:0]  exp_q[$];
  logic [2*K-1:0] hist[$];
  logic [K-1:0]   rnd_t0 [MAXI];
  logic [K-1:0]   rnd_t1 [MAXI];
  int             exp_gid [MAXI];
  int             n_exp = 0;
  int             k = 0;
  int             pass_cnt = 0;
  int             chk_cnt = 0;
  int             done_cnt = 0;
  int             cyc = 0;
  int             ready_mode = 0;
  int             first_issue_cyc = -1;
  int             last_issue_cyc = -1;
  int             first_valid_cyc = -1;

  function automatic logic [K-1:0] rand_k();
    logic [K-1:0] v;
    v = '0;
    for (int i = 0; i < K; i += 32) v = (v << 32) | K'($urandom);
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic check_entry(input logic [EW-1:0] act, input logic [EW-1:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL gt_entry: got %h expected %h", act, exp);
  endtask

  task automatic fail_msg(input string name);
    chk_cnt++;
    $display("FAIL %s: event missing or unexpected", name);
  endtask

  // ---------------- driver tasks ----------------
  // Build the expected stream for (ng, ncc) and pulse start for one cycle.
  task automatic launch(input int ng, input int ncc);
    int nce;
    int idx;
    nce = (ncc == 0) ? 1 : ncc;
    n_exp = 0;
    k = 0;
    first_issue_cyc = -1;
    last_issue_cyc = -1;
    first_valid_cyc = -1;
    for (int c = 0; c < nce; c++) begin
      idx = 0;
      for (int g = 0; g < ng; g++) begin
        if (!xor_flag[g]) begin
          rnd_t0[n_exp] = rand_k();
          rnd_t1[n_exp] = rand_k();
          exp_gid[n_exp] = g;
          exp_q.push_back({rnd_t1[n_exp], rnd_t0[n_exp], S'(idx), CCW'(c)});
          idx++;
          n_exp++;
        end
      end
    end
    num_gates = S'(ng);
    num_cc = CCW'(ncc);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, input int d0, input string tag);
    int n;
    n = 0;
    while (done_cnt == d0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (done_cnt == d0) fail_msg({tag, "_timeout"});
    repeat (3) @(negedge clk);
    check({tag, "_done_once"}, done_cnt - d0, 1);
    check({tag, "_all_out"}, exp_q.size(), 0);
    check({tag, "_issues"}, k, n_exp);
    check({tag, "_idle"}, busy, 0);
  endtask

  // ---------------- consumer, monitor and engine model ----------------
  initial begin
    logic [EW-1:0]  e;
    logic [2*K-1:0] w;
    forever begin
      @(negedge clk);
      cyc++;
      case (ready_mode)
        0:       gt_ready = 1'b1;
        1:       gt_ready = 1'b0;
        default: gt_ready = 1'($urandom_range(0, 1));
      endcase
      if (!rst && gt_valid === 1'b1 && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (!rst && gt_valid === 1'b1 && gt_ready) begin
        if (exp_q.size() == 0) fail_msg("extra_entry");
        else begin
          e = exp_q.pop_front();
          check_entry({gt_data, gt_idx, gt_cc}, e);
        end
      end
      #1;
      if (done === 1'b1) done_cnt++;
      if (rst) begin
        hist.delete();
        exp_q.delete();
        n_exp = 0;
        k = 0;
      end else begin
        if (eng_issue === 1'b1) begin
          if (k < n_exp) begin
            check("issue_gid", gid, exp_gid[k]);
            hist.push_back({rnd_t1[k], rnd_t0[k]});
          end else begin
            fail_msg("extra_issue");
            hist.push_back({rand_k(), rand_k()});
          end
          if (first_issue_cyc < 0) first_issue_cyc = cyc;
          last_issue_cyc = cyc;
          k++;
        end else begin
          hist.push_back({rand_k(), rand_k()});
        end
        if (hist.size() > LAT) begin
          w = hist.pop_front();
          eng_t0 = w[K-1:0];
          eng_t1 = w[2*K-1:K];
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // ---------------- test sequence ----------------
  initial begin
    int d0;
    int n;
    for (int i = 0; i < MAXG; i++) xor_flag[i] = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_gid", gid, 0);
    check("rst_issue", eng_issue, 0);
    check("rst_gt_valid", gt_valid, 0);
    check("rst_gt_data", {63'd0, |gt_data}, 0);
    check("rst_gt_idx", gt_idx, 0);
    check("rst_gt_cc", gt_cc, 0);
    rst = 1'b0;
    @(negedge clk);

    // Four non-free gates, one CC, consumer always ready.
    ready_mode = 0;
    d0 = done_cnt;
    launch(4, 1);
    wait_done(200, d0, "t4");
    check("t4_consecutive", last_issue_cyc - first_issue_cyc, 3);
    check("t4_latency", first_valid_cyc - first_issue_cyc, LAT + 1);

    // X,A,X,A over three CCs: idx 0,1 per CC, gid wraps 3->0.
    xor_flag[0] = 1'b1; xor_flag[1] = 1'b0; xor_flag[2] = 1'b1; xor_flag[3] = 1'b0;
    d0 = done_cnt;
    launch(4, 3);
    wait_done(300, d0, "xaxa");

    // 40 non-free gates with the consumer blocked: credit stops issue at FD.
    for (int i = 0; i < MAXG; i++) xor_flag[i] = 1'b0;
    ready_mode = 1;
    d0 = done_cnt;
    launch(40, 1);
    repeat (60) @(negedge clk);
    check("bp_issues", k, FD);
    check("bp_stalled", eng_issue, 0);
    check("bp_gid_held", gid, FD);
    check("bp_busy", busy, 1);
    check("bp_gt_valid", gt_valid, 1);
    ready_mode = 0;
    wait_done(600, d0, "bp");

    // num_gates=0: one RUN cycle, no issue, done three cycles after start.
    d0 = done_cnt;
    launch(0, 1);
    check("ng0_done_c1", done, 0);
    @(negedge clk);
    check("ng0_done_c2", done, 0);
    @(negedge clk);
    check("ng0_done_c3", done, 1);
    wait_done(20, d0, "ng0");

    // num_cc=0 behaves as a single CC.
    d0 = done_cnt;
    launch(3, 0);
    wait_done(200, d0, "cc0");

    // Reset in the middle of a run, then a clean run with no stale entries.
    launch(20, 2);
    n = 0;
    while (k < 5 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("mid_issued", k >= 5, 1);
    rst = 1'b1;
    @(negedge clk);
    check("mid_busy", busy, 0);
    check("mid_gid", gid, 0);
    check("mid_issue", eng_issue, 0);
    check("mid_gt_valid", gt_valid, 0);
    check("mid_state", state_dbg, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (LAT + 3) @(negedge clk);
    check("post_rst_gt_valid", gt_valid, 0);
    d0 = done_cnt;
    launch(8, 2);
    wait_done(300, d0, "clean");

    // 100 gates, ~50% free, two CCs, random consumer backpressure.
    for (int i = 0; i < 100; i++) xor_flag[i] = 1'($urandom_range(0, 1));
    ready_mode = 2;
    d0 = done_cnt;
    launch(100, 2);
    wait_done(4000, d0, "rand");

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
